// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel between the I-Cache refill port and the
// data-side read port. Each requester may have one read outstanding (IDs 0 and 1);
// returning beats are steered back by rid.
// Build option: define RR_ARB_EN for round-robin arbitration between simultaneous
// requests; by default the data side wins over the I-Cache.
module axi_rd_arbiter (
  input  logic        clk,
  input  logic        reset,
  // I-Cache side
  input  logic        ic_rd_req,
  input  logic [2:0]  ic_rd_type,
  input  logic [31:0] ic_rd_addr,
  output logic        ic_rd_rdy,
  output logic        ic_ret_valid,
  output logic        ic_ret_last,
  output logic [31:0] ic_ret_data,
  // Data side
  input  logic        d_rd_req,
  input  logic [1:0]  d_rd_size,
  input  logic [31:0] d_rd_addr,
  output logic        d_rd_addr_ok,
  output logic        d_rd_data_ok,
  output logic [31:0] d_rd_rdata,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {StIdle, StArIc, StArD} state_e;

  state_e      state_q;
  logic [1:0]  busy_q, busy_d;   // bit 0: I-Cache read outstanding, bit 1: data read
  logic        arvalid_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;
  logic [2:0]  arsize_q;
  logic        ic_elig, d_elig, grant_ic, grant_d;
  logic        beat_ic, beat_d;

  // Eligibility uses the registered busy flags, so a requester freed by rlast can only be
  // granted again from the following cycle.
  assign ic_elig = ic_rd_req && !busy_q[0];
  assign d_elig  = d_rd_req && !busy_q[1];

`ifdef RR_ARB_EN
  logic ptr_q;  // 0: I-Cache wins the next tie, 1: data wins

  assign grant_ic = ic_elig && (!d_elig || !ptr_q);
  assign grant_d  = d_elig && (!ic_elig || ptr_q);
`else
  assign grant_d  = d_elig;
  assign grant_ic = ic_elig && !d_elig;
`endif

  // Request acceptance and R-channel steering are combinational on the handshake/beat.
  always_comb begin
    ic_rd_rdy    = (state_q == StArIc) && arready;
    d_rd_addr_ok = (state_q == StArD) && arready;
    beat_ic      = rvalid && (rid == 4'd0);
    beat_d       = rvalid && (rid == 4'd1);
    ic_ret_valid = beat_ic;
    ic_ret_last  = beat_ic && rlast;
    ic_ret_data  = beat_ic ? rdata : 32'd0;
    d_rd_data_ok = beat_d;
    d_rd_rdata   = beat_d ? rdata : 32'd0;
    rready       = 1'b1;
  end

  // Busy flags: cleared by the final beat, set by the AR handshake.
  always_comb begin
    busy_d = busy_q;
    if (beat_ic && rlast) busy_d[0] = 1'b0;
    if (beat_d && rlast)  busy_d[1] = 1'b0;
    if (ic_rd_rdy)        busy_d[0] = 1'b1;
    if (d_rd_addr_ok)     busy_d[1] = 1'b1;
  end

  assign arvalid = arvalid_q;
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;

  // AR FSM: grant in idle, latch the AR fields, hold them until arready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      busy_q    <= 2'b00;
      arvalid_q <= 1'b0;
      arid_q    <= 4'd0;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      arsize_q  <= 3'd0;
`ifdef RR_ARB_EN
      ptr_q     <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q   <= StArD;
            arvalid_q <= 1'b1;
            arid_q    <= 4'd1;
            araddr_q  <= d_rd_addr;
            arlen_q   <= 8'd0;
            arsize_q  <= {1'b0, d_rd_size};
`ifdef RR_ARB_EN
            ptr_q     <= 1'b0;
`endif
          end else if (grant_ic) begin
            state_q   <= StArIc;
            arvalid_q <= 1'b1;
            arid_q    <= 4'd0;
            araddr_q  <= ic_rd_addr;
            arlen_q   <= (ic_rd_type == 3'b100) ? 8'd3 : 8'd0;
            arsize_q  <= 3'b010;
`ifdef RR_ARB_EN
            ptr_q     <= 1'b1;
`endif
          end
        end
        StArIc, StArD: begin
          if (arready) begin
            state_q   <= StIdle;
            arvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          arvalid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: a table of R-channel routing vectors, directed
// multi-cycle sequences, then randomized traffic against a transaction-level model.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_rd_req;
  logic [2:0]  ic_rd_type;
  logic [31:0] ic_rd_addr;
  logic        ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic [31:0] ic_ret_data;
  logic        d_rd_req;
  logic [1:0]  d_rd_size;
  logic [31:0] d_rd_addr;
  logic        d_rd_addr_ok, d_rd_data_ok;
  logic [31:0] d_rd_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .ic_rd_req    (ic_rd_req),
    .ic_rd_type   (ic_rd_type),
    .ic_rd_addr   (ic_rd_addr),
    .ic_rd_rdy    (ic_rd_rdy),
    .ic_ret_valid (ic_ret_valid),
    .ic_ret_last  (ic_ret_last),
    .ic_ret_data  (ic_ret_data),
    .d_rd_req     (d_rd_req),
    .d_rd_size    (d_rd_size),
    .d_rd_addr    (d_rd_addr),
    .d_rd_addr_ok (d_rd_addr_ok),
    .d_rd_data_ok (d_rd_data_ok),
    .d_rd_rdata   (d_rd_rdata),
    .arid         (arid),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arvalid      (arvalid),
    .arready      (arready),
    .rid          (rid),
    .rdata        (rdata),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ic_rd_req = 1'b0; ic_rd_type = 3'd0; ic_rd_addr = 32'd0;
    d_rd_req = 1'b0; d_rd_size = 2'd0; d_rd_addr = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rlast = 1'b0; rvalid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  // Returns at a negedge where arvalid is high, or flags a timeout.
  task automatic wait_arvalid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      smp();
      if (arvalid) seen = 1'b1;
      else step();
    end
    if (!seen) chk({name, "_arvalid_timeout"}, 32'd0, 32'd1);
  endtask

  // Drives one R beat for a cycle and checks where it is routed.
  task automatic beat(input logic [3:0] id, input logic [31:0] data, input logic last);
    rvalid = 1'b1; rid = id; rdata = data; rlast = last;
    smp();
    chk("beat_ic_valid", 32'(ic_ret_valid), 32'(id == 4'd0));
    chk("beat_ic_last", 32'(ic_ret_last), 32'((id == 4'd0) && last));
    chk("beat_d_ok", 32'(d_rd_data_ok), 32'(id == 4'd1));
    if (id == 4'd0) chk("beat_ic_data", ic_ret_data, data);
    if (id == 4'd1) chk("beat_d_data", d_rd_rdata, data);
    step();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  typedef struct {
    logic        rvalid;
    logic [3:0]  rid;
    logic        rlast;
    logic [31:0] rdata;
    logic        e_icv;
    logic        e_icl;
    logic        e_dok;
  } vec_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   n;
    logic [3:0]  got;
    logic [31:0] held_addr;
    // model state for the random phase
    bit   pend;
    ar_t  rec;
    bit   busy_m[2];
    int   rem[2];
    bit   ptr_m;

    tbl[0] = '{1'b1, 4'd0,  1'b0, 32'h1111_0000, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 4'd0,  1'b1, 32'h2222_0001, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 4'd1,  1'b0, 32'h3333_0002, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 4'd1,  1'b1, 32'h4444_0003, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 4'd0,  1'b1, 32'h5555_0004, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 4'd2,  1'b1, 32'h6666_0005, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 4'd15, 1'b0, 32'h7777_0006, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 4'd1,  1'b1, 32'h8888_0007, 1'b0, 1'b0, 1'b0};

    idle_inputs();
    reset = 1'b1;
    #1;
    do_reset();

    // Reset state
    smp();
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_arid", 32'(arid), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arlen", 32'(arlen), 32'd0);
    chk("rst_arsize", 32'(arsize), 32'd0);
    chk("rst_rdy", 32'(ic_rd_rdy), 32'd0);
    chk("rst_addr_ok", 32'(d_rd_addr_ok), 32'd0);
    chk("rst_rready", 32'(rready), 32'd1);
    step();

    // R routing table
    foreach (tbl[i]) begin
      rvalid = tbl[i].rvalid; rid = tbl[i].rid; rlast = tbl[i].rlast; rdata = tbl[i].rdata;
      smp();
      chk("tbl_ic_valid", 32'(ic_ret_valid), 32'(tbl[i].e_icv));
      chk("tbl_ic_last", 32'(ic_ret_last), 32'(tbl[i].e_icl));
      chk("tbl_d_ok", 32'(d_rd_data_ok), 32'(tbl[i].e_dok));
      if (tbl[i].e_icv) chk("tbl_ic_data", ic_ret_data, tbl[i].rdata);
      if (tbl[i].e_dok) chk("tbl_d_data", d_rd_rdata, tbl[i].rdata);
      chk("tbl_arvalid", 32'(arvalid), 32'd0);
      step();
    end
    idle_inputs();

    // I-Cache line read
    ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0010; arready = 1'b1;
    wait_arvalid("ic_line");
    chk("ic_line_arid", 32'(arid), 32'd0);
    chk("ic_line_arlen", 32'(arlen), 32'd3);
    chk("ic_line_arsize", 32'(arsize), 32'd2);
    chk("ic_line_araddr", araddr, 32'h1C00_0010);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (ic_rd_rdy) n++;
      step();
      ic_rd_req = 1'b0;
      smp();
    end
    chk("ic_line_rdy_pulses", 32'(n), 32'd1);
    step();
    for (int i = 0; i < 4; i++) beat(4'd0, 32'hC0DE_0000 + 32'(i), i == 3);

    // Data read
    d_rd_req = 1'b1; d_rd_size = 2'b01; d_rd_addr = 32'h0000_0102;
    wait_arvalid("d_rd");
    chk("d_rd_arid", 32'(arid), 32'd1);
    chk("d_rd_arlen", 32'(arlen), 32'd0);
    chk("d_rd_arsize", 32'(arsize), 32'd1);
    chk("d_rd_araddr", araddr, 32'h0000_0102);
    chk("d_rd_addr_ok", 32'(d_rd_addr_ok), 32'd1);
    step();
    d_rd_req = 1'b0;
    beat(4'd1, 32'h0000_ABCD, 1'b1);

    // Simultaneous requests, each transaction completed before the next decision
    for (int g = 0; g < 4; g++) begin
      ic_rd_req = 1'b1; ic_rd_type = 3'd0; d_rd_req = 1'b1; arready = 1'b1;
      wait_arvalid("arb");
      got = arid;
`ifdef RR_ARB_EN
      chk("arb_grant", 32'(got), 32'(g % 2));
`else
      chk("arb_grant", 32'(got), 32'd1);
`endif
      step();
      ic_rd_req = 1'b0; d_rd_req = 1'b0;
      beat(got, 32'(g), 1'b1);
    end

    // AR stall: fields must hold while arready is low
    arready = 1'b0; d_rd_req = 1'b1; d_rd_size = 2'b10; d_rd_addr = 32'h2000_0008;
    wait_arvalid("stall");
    for (int i = 0; i < 5; i++) begin
      chk("stall_arvalid", 32'(arvalid), 32'd1);
      chk("stall_araddr", araddr, 32'h2000_0008);
      chk("stall_arid", 32'(arid), 32'd1);
      chk("stall_arlen", 32'(arlen), 32'd0);
      chk("stall_arsize", 32'(arsize), 32'd2);
      chk("stall_addr_ok", 32'(d_rd_addr_ok), 32'd0);
      step();
      d_rd_addr = $urandom; d_rd_size = 2'd0;
      smp();
    end
    arready = 1'b1;
    #1;
    chk("stall_release_ok", 32'(d_rd_addr_ok), 32'd1);
    chk("stall_release_addr", araddr, 32'h2000_0008);
    step();
    d_rd_req = 1'b0;
    beat(4'd1, 32'h5A5A_0001, 1'b1);

    // IC line outstanding, second IC request held, data read interleaved
    arready = 1'b1; ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h0000_0100;
    wait_arvalid("ovl_ic");
    chk("ovl_ic_rdy", 32'(ic_rd_rdy), 32'd1);
    step();
    ic_rd_type = 3'd0; ic_rd_addr = 32'h0000_0140;
    d_rd_req = 1'b1; d_rd_size = 2'b10; d_rd_addr = 32'h0000_0200;
    wait_arvalid("ovl_d");
    chk("ovl_d_arid", 32'(arid), 32'd1);
    chk("ovl_d_ok", 32'(d_rd_addr_ok), 32'd1);
    step();
    d_rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      got = (i == 1) ? 4'd1 : 4'd0;
      rvalid = 1'b1; rid = got; rdata = 32'hBEEF_0000 + 32'(i); rlast = (i == 1) || (i == 4);
      smp();
      chk("ovl_no_second_ar", 32'(arvalid), 32'd0);
      chk("ovl_ic_valid", 32'(ic_ret_valid), 32'(got == 4'd0));
      chk("ovl_ic_last", 32'(ic_ret_last), 32'(i == 4));
      chk("ovl_d_ok", 32'(d_rd_data_ok), 32'(got == 4'd1));
      if (got == 4'd1) chk("ovl_d_data", d_rd_rdata, 32'hBEEF_0001);
      step();
      rvalid = 1'b0; rlast = 1'b0;
    end
    smp();
    chk("ovl_after_last_grant_cycle", 32'(arvalid), 32'd0);
    step();
    smp();
    chk("ovl_second_ar", 32'(arvalid), 32'd1);
    chk("ovl_second_arid", 32'(arid), 32'd0);
    chk("ovl_second_araddr", araddr, 32'h0000_0140);
    step();
    ic_rd_req = 1'b0;
    beat(4'd0, 32'h1234_5678, 1'b1);

    // Reset while in AR_D with the IC side busy
    arready = 1'b1; ic_rd_req = 1'b1; ic_rd_type = 3'd0; ic_rd_addr = 32'h0000_0300;
    wait_arvalid("rst_ic");
    step();
    ic_rd_req = 1'b0; arready = 1'b0;
    d_rd_req = 1'b1; d_rd_addr = 32'h0000_0400;
    wait_arvalid("rst_d");
    chk("rst_d_arid", 32'(arid), 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; d_rd_req = 1'b0;
    smp();
    chk("rst_mid_arvalid", 32'(arvalid), 32'd0);
    chk("rst_mid_araddr", araddr, 32'd0);
    chk("rst_mid_arid", 32'(arid), 32'd0);
    step();
    ic_rd_req = 1'b1; arready = 1'b1; ic_rd_addr = 32'h0000_0500;
    wait_arvalid("rst_busy_cleared");
    chk("rst_busy_cleared_arid", 32'(arid), 32'd0);
    chk("rst_busy_cleared_addr", araddr, 32'h0000_0500);
    step();

    // Randomized traffic against a transaction-level model
    do_reset();
    pend = 1'b0; busy_m = '{1'b0, 1'b0}; rem = '{0, 0}; ptr_m = 1'b0;
    rec = '{4'd0, 32'd0, 8'd0, 3'd0};
    for (int c = 0; c < 3000; c++) begin
      int r;
      bit e0, e1, gr;
      int pick;
      ic_rd_req  = 1'($urandom_range(0, 1));
      ic_rd_type = $urandom_range(0, 1) ? 3'b100 : 3'($urandom_range(0, 7));
      ic_rd_addr = $urandom;
      d_rd_req   = 1'($urandom_range(0, 1));
      d_rd_size  = 2'($urandom_range(0, 3));
      d_rd_addr  = $urandom;
      arready    = ($urandom_range(0, 3) != 0);
      rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; rdata = $urandom;
      r = $urandom_range(0, 7);
      if (r < 3 && rem[0] > 0) begin
        rvalid = 1'b1; rid = 4'd0; rlast = (rem[0] == 1);
      end else if (r >= 3 && r < 6 && rem[1] > 0) begin
        rvalid = 1'b1; rid = 4'd1; rlast = (rem[1] == 1);
      end else if (r == 7) begin
        rvalid = 1'b1; rid = 4'($urandom_range(2, 15)); rlast = 1'($urandom_range(0, 1));
      end
      smp();
      chk("rnd_arvalid", 32'(arvalid), 32'(pend));
      if (pend) begin
        chk("rnd_arid", 32'(arid), 32'(rec.id));
        chk("rnd_araddr", araddr, rec.addr);
        chk("rnd_arlen", 32'(arlen), 32'(rec.len));
        chk("rnd_arsize", 32'(arsize), 32'(rec.size));
      end
      chk("rnd_ic_rdy", 32'(ic_rd_rdy), 32'(pend && rec.id == 4'd0 && arready));
      chk("rnd_d_addr_ok", 32'(d_rd_addr_ok), 32'(pend && rec.id == 4'd1 && arready));
      chk("rnd_ic_valid", 32'(ic_ret_valid), 32'(rvalid && rid == 4'd0));
      chk("rnd_ic_last", 32'(ic_ret_last), 32'(rvalid && rid == 4'd0 && rlast));
      chk("rnd_d_ok", 32'(d_rd_data_ok), 32'(rvalid && rid == 4'd1));
      if (rvalid && rid == 4'd0) chk("rnd_ic_data", ic_ret_data, rdata);
      if (rvalid && rid == 4'd1) chk("rnd_d_data", d_rd_rdata, rdata);
      chk("rnd_rready", 32'(rready), 32'd1);

      // Advance the model: decisions use the busy state from before this cycle's updates.
      gr = 1'b0; pick = 0;
      if (!pend) begin
        e0 = ic_rd_req && !busy_m[0];
        e1 = d_rd_req && !busy_m[1];
        if (e0 || e1) begin
          gr = 1'b1;
`ifdef RR_ARB_EN
          pick = (e0 && e1) ? int'(ptr_m) : (e1 ? 1 : 0);
`else
          pick = e1 ? 1 : 0;
`endif
        end
      end
      if (rvalid && rid < 4'd2) begin
        rem[rid[0]]--;
        if (rlast) busy_m[rid[0]] = 1'b0;
      end
      if (pend && arready) begin
        busy_m[rec.id[0]] = 1'b1;
        rem[rec.id[0]] = int'(rec.len) + 1;
        pend = 1'b0;
      end else if (gr) begin
        pend = 1'b1;
        ptr_m = (pick == 0);
        if (pick == 1) rec = '{4'd1, d_rd_addr, 8'd0, {1'b0, d_rd_size}};
        else rec = '{4'd0, ic_rd_addr, (ic_rd_type == 3'b100) ? 8'd3 : 8'd0, 3'b010};
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
